// File: rtl/garage_pkg.sv
// ============================================================================
// Module      : garage_pkg
// Description : Shared state and direction types for the barrier-gate control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package garage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } gate_state_t;

    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } dir_t;

endpackage : garage_pkg

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..TICK_DIV-1 counter producing a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Tick must not depend on clear: clear is itself derived from tick upstream.
    assign tick = (r_cnt == c_LAST);

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/gate_sequencer.sv
// ============================================================================
// Module      : gate_sequencer
// Description : Barrier-gate FSM with round-robin entry/exit arbitration,
//               tick-timed motor phases and lot occupancy tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sequencer
    import garage_pkg::*;
#(
    parameter int SLOTS      = 8,
    parameter int TICK_DIV   = 100,
    parameter int OPEN_TICKS = 3,
    parameter int HOLD_TICKS = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       entry_req,
    input  logic                       exit_req,
    input  logic                       pass_done,
    output logic                       grant_entry,
    output logic                       grant_exit,
    output logic                       gate_open,
    output logic                       gate_close,
    output logic                       gate_busy,
    output logic                       lot_full,
    output logic [$clog2(SLOTS+1)-1:0] occupancy
);

    localparam int                  c_OCC_W     = $clog2(SLOTS + 1);
    localparam logic [c_OCC_W-1:0]  c_SLOTS     = c_OCC_W'(SLOTS);
    localparam logic [c_OCC_W-1:0]  c_OCC_ONE   = c_OCC_W'(1);
    localparam int                  c_MAX_TICKS = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
    localparam int                  c_TCNT_W    = $clog2(c_MAX_TICKS + 1);
    localparam logic [c_TCNT_W-1:0] c_OPEN_LAST = c_TCNT_W'(OPEN_TICKS - 1);
    localparam logic [c_TCNT_W-1:0] c_HOLD_LAST = c_TCNT_W'(HOLD_TICKS - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = c_TCNT_W'(1);

    gate_state_t         r_state;
    gate_state_t         w_state_next;
    dir_t                r_dir;
    dir_t                w_dir_next;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [c_OCC_W-1:0]  w_occ_next;
    logic                w_grant_entry;
    logic                w_grant_exit;
    logic                w_entry_ok;
    logic                w_exit_ok;
    logic                w_tick;
    logic                w_clear;

    assign w_entry_ok = entry_req && !lot_full;
    assign w_exit_ok  = exit_req && (occupancy != '0);
    assign w_clear    = (w_state_next != r_state);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_dir doubles as the round-robin pointer: it remembers the last direction served.
    always_comb begin
        w_state_next  = r_state;
        w_dir_next    = r_dir;
        w_occ_next    = occupancy;
        w_grant_entry = 1'b0;
        w_grant_exit  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_entry_ok && (!w_exit_ok || (r_dir == EXIT))) begin
                    w_dir_next    = ENTRY;
                    w_grant_entry = 1'b1;
                    w_state_next  = OPENING;
                end else if (w_exit_ok) begin
                    w_dir_next    = EXIT;
                    w_grant_exit  = 1'b1;
                    w_state_next  = OPENING;
                end
            end
            OPENING: begin
                if (w_tick && (r_tcnt == c_OPEN_LAST)) begin
                    w_state_next = OPEN;
                end
            end
            OPEN: begin
                if (pass_done) begin
                    if ((r_dir == ENTRY) && (occupancy != c_SLOTS)) begin
                        w_occ_next = occupancy + c_OCC_ONE;
                    end else if ((r_dir == EXIT) && (occupancy != '0)) begin
                        w_occ_next = occupancy - c_OCC_ONE;
                    end
                    w_state_next = CLOSING;
                end else if (w_tick && (r_tcnt == c_HOLD_LAST)) begin
                    w_state_next = CLOSING;
                end
            end
            CLOSING: begin
                if (w_tick && (r_tcnt == c_OPEN_LAST)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir       <= EXIT;
            r_tcnt      <= '0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            gate_open   <= 1'b0;
            gate_close  <= 1'b0;
            gate_busy   <= 1'b0;
            lot_full    <= 1'b0;
            occupancy   <= '0;
        end else begin
            r_dir       <= w_dir_next;
            if (w_clear) begin
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + c_TCNT_ONE;
            end
            grant_entry <= w_grant_entry;
            grant_exit  <= w_grant_exit;
            gate_open   <= (w_state_next == OPENING);
            gate_close  <= (w_state_next == CLOSING);
            gate_busy   <= (w_state_next != IDLE);
            lot_full    <= (w_occ_next == c_SLOTS);
            occupancy   <= w_occ_next;
        end
    end

endmodule : gate_sequencer

`default_nettype wire

// File: tb/tb_gate_sequencer.sv
// ============================================================================
// Module      : tb_gate_sequencer
// Description : Scoreboard bench for gate_sequencer (SLOTS=2, TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gate_sequencer;

    localparam int SLOTS      = 2;
    localparam int TICK_DIV   = 4;
    localparam int OPEN_TICKS = 2;
    localparam int HOLD_TICKS = 3;
    localparam int OPEN_LEN   = OPEN_TICKS * TICK_DIV;
    localparam int HOLD_LEN   = HOLD_TICKS * TICK_DIV;
    localparam int BOUND      = 200;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req  = 1'b0;
    logic       pass_done = 1'b0;
    logic       grant_entry;
    logic       grant_exit;
    logic       gate_open;
    logic       gate_close;
    logic       gate_busy;
    logic       lot_full;
    logic [1:0] occupancy;

    int n_cmp     = 0;
    int n_err     = 0;
    int occ_model = 0;
    bit exp_q[$];
    bit exp_dir;
    bit prev_busy = 1'b0;

    always #5 clk = ~clk;

    gate_sequencer #(
        .SLOTS      (SLOTS),
        .TICK_DIV   (TICK_DIV),
        .OPEN_TICKS (OPEN_TICKS),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pass_done   (pass_done),
        .grant_entry (grant_entry),
        .grant_exit  (grant_exit),
        .gate_open   (gate_open),
        .gate_close  (gate_close),
        .gate_busy   (gate_busy),
        .lot_full    (lot_full),
        .occupancy   (occupancy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Grant direction scoreboard and motor-exclusion monitor.
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (grant_entry || grant_exit) begin
                check_eq("grant_idle_before", prev_busy, 0);
                if (exp_q.size() == 0) begin
                    check_eq("grant_unexpected", {grant_exit, grant_entry}, 0);
                end else begin
                    exp_dir = exp_q.pop_front();
                    check_eq("grant_dir", {grant_exit, grant_entry}, exp_dir ? 2 : 1);
                end
            end
            if (gate_open || gate_close) begin
                check_eq("motor_exclusive", gate_open & gate_close, 0);
            end
            prev_busy = gate_busy;
        end
    end

    task automatic check_rst(input string tag);
        check_eq(tag, {grant_entry, grant_exit, gate_open, gate_close, gate_busy, lot_full}, 0);
        check_eq(tag, occupancy, 0);
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!(grant_entry || grant_exit) && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        check_eq("grant_seen", grant_entry | grant_exit, 1);
    endtask

    // One full gate cycle from grant to return to IDLE; rel drops {exit,entry} at grant.
    task automatic do_txn(input bit is_exit, input bit pass, input bit stray, input logic [1:0] rel);
        int n;
        wait_grant();
        if (rel[0]) entry_req = 1'b0;
        if (rel[1]) exit_req  = 1'b0;
        check_eq("open_at_grant", gate_open, 1);
        n = 0;
        while (gate_open && n < BOUND) begin
            n++;
            pass_done = stray && (n == 3);
            @(negedge clk);
        end
        pass_done = 1'b0;
        check_eq("open_len", n, OPEN_LEN);
        check_eq("open_motor_off", {gate_open, gate_close}, 0);
        check_eq("busy_in_open", gate_busy, 1);
        check_eq("occ_in_open", occupancy, occ_model);
        if (pass) begin
            pass_done = 1'b1;
            @(negedge clk);
            pass_done = 1'b0;
            occ_model += is_exit ? -1 : 1;
            check_eq("close_after_pass", gate_close, 1);
            check_eq("occ_after_pass", occupancy, occ_model);
            check_eq("full_after_pass", lot_full, int'(occ_model == SLOTS));
        end else begin
            n = 0;
            while (!gate_close && n < BOUND) begin
                n++;
                @(negedge clk);
            end
            check_eq("hold_len", n, HOLD_LEN);
            check_eq("occ_after_timeout", occupancy, occ_model);
        end
        n = 0;
        while (gate_close && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        check_eq("close_len", n, OPEN_LEN);
        check_eq("idle_after_close", {gate_busy, gate_open, gate_close}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        check_rst("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        check_rst("rst_out");

        // Exit with empty lot and stray pass_done in IDLE are ignored.
        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pass_done = (i == 4);
            @(negedge clk);
        end
        pass_done = 1'b0;
        check_eq("empty_exit_busy", gate_busy, 0);
        check_eq("empty_exit_occ", occupancy, 0);
        exit_req = 1'b0;

        // Single entry with a stray pass_done during OPENING.
        exp_q.push_back(1'b0);
        entry_req = 1'b1;
        do_txn(1'b0, 1'b1, 1'b1, 2'b01);

        // Exit-only request that times out.
        exp_q.push_back(1'b1);
        exit_req = 1'b1;
        do_txn(1'b1, 1'b0, 1'b0, 2'b10);

        // Both held: round-robin entry, exit, entry.
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        do_txn(1'b0, 1'b0, 1'b0, 2'b00);
        do_txn(1'b1, 1'b0, 1'b0, 2'b00);
        do_txn(1'b0, 1'b0, 1'b0, 2'b11);

        // Fill the lot.
        exp_q.push_back(1'b0);
        entry_req = 1'b1;
        do_txn(1'b0, 1'b1, 1'b0, 2'b01);

        // Full lot refuses entry; an exit frees a slot and entry follows.
        entry_req = 1'b1;
        g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_entry || grant_exit) g++;
        end
        check_eq("full_no_grant", g, 0);
        check_eq("full_flag", lot_full, 1);
        check_eq("full_idle", gate_busy, 0);
        exp_q.push_back(1'b1);
        exit_req = 1'b1;
        do_txn(1'b1, 1'b1, 1'b0, 2'b10);
        check_eq("full_cleared", lot_full, 0);
        exp_q.push_back(1'b0);
        do_txn(1'b0, 1'b0, 1'b0, 2'b01);

        // Reset during OPENING aborts at once.
        exp_q.push_back(1'b0);
        entry_req = 1'b1;
        wait_grant();
        entry_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_reset_open", gate_open, 1);
        reset = 1'b1;
        #1;
        check_rst("rst_async");
        @(negedge clk);
        reset = 1'b0;
        occ_model = 0;
        @(negedge clk);
        check_rst("rst_released");
        exp_q.push_back(1'b0);
        entry_req = 1'b1;
        do_txn(1'b0, 1'b1, 1'b0, 2'b01);

        check_eq("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gate_sequencer

`default_nettype wire
